// File: rtl/parity_frame_rx.sv
// parity_frame_rx
// ---------------------------------------------------------------------------
// Serial parity-checking frame receiver. Accepts a one-bit serial stream
// framed as: start bit (0), DATA_W data bits MSB-first, one parity bit and
// one stop bit (1). Reassembles the data word, recomputes XOR parity over the
// data and parity bits, and reports the word plus parity/framing status as a
// one-cycle result pulse.
//
// Configuration macro:
//   PARITY_FRAME_RX_ODD_EN  defined   -> odd parity  (data ^ parity must be 1)
//                           undefined -> even parity (data ^ parity must be 0)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    in_bit is meaningful this cycle; bits consumed only when high
//   in_bit      serial line bit
//   busy        high while a frame is in progress
//   out_valid   one-cycle pulse, frame result available
//   out_data    received data word, held until the next out_valid
//   parity_err  parity mismatch, held until the next out_valid
//   frame_err   stop bit was 0, held until the next out_valid
// ---------------------------------------------------------------------------
module parity_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef PARITY_FRAME_RX_ODD_EN
  localparam logic EXP_PAR = 1'b1;
`else
  localparam logic EXP_PAR = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    // Nothing advances without in_valid, so gaps are allowed in any state.
    if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (!in_bit) begin
            state_d = DATA;
            cnt_d   = '0;
            par_d   = 1'b0;
          end
        end
        DATA: begin
          // Shift in from the LSB side: first data bit ends up at the MSB.
          shift_d = {shift_q[DATA_W-2:0], in_bit};
          par_d   = par_q ^ in_bit;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = par_q ^ in_bit;
          state_d = STOP;
        end
        STOP: begin
          // par_q already covers data and parity bits at this point.
          state_d      = IDLE;
          out_data_d   = shift_q;
          parity_err_d = (par_q != EXP_PAR);
          frame_err_d  = ~in_bit;
          out_valid_d  = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Registered busy mirrors the next state so it tracks state_q exactly.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx (DATA_W=8). Inputs are driven on
// the falling edge and outputs are sampled on the falling edge.
module tb_parity_frame_rx;

  localparam int DATA_W = 8;

`ifdef PARITY_FRAME_RX_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_bit;
  logic              busy;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              parity_err;
  logic              frame_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc;

  parity_frame_rx #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input logic v, input logic b);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
  endtask

  task automatic send_body(input logic [DATA_W-1:0] data, input logic par,
                           input logic stop, input int gap4, input int gap_stop);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      drive(1'b1, data[i]);
      if (i == DATA_W - 4) repeat (gap4) drive(1'b0, 1'b0);
    end
    drive(1'b1, par);
    repeat (gap_stop) drive(1'b0, 1'b1);
    drive(1'b1, stop);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] data, input logic par,
                            input logic stop, input int gap4, input int gap_stop);
    drive(1'b1, 1'b0);
    start_cyc = cyc;
    send_body(data, par, stop, gap4, gap_stop);
  endtask

  // Idles the line until out_valid appears (bounded), then checks the
  // result, the latency from the start bit, and the one-cycle pulse width.
  task automatic check_result(input string name, input logic [DATA_W-1:0] exp_data,
                              input logic exp_perr, input logic exp_ferr,
                              input int exp_lat);
    bit found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      drive(1'b0, 1'b1);
      if (out_valid === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s_timeout: out_valid never rose within 30 cycles", name);
    end else begin
      checks++;
      if ((cyc - start_cyc) != exp_lat) begin
        failures++;
        $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cyc - start_cyc, exp_lat);
      end
      checks++;
      if (out_data !== exp_data || parity_err !== exp_perr || frame_err !== exp_ferr) begin
        failures++;
        $display("FAIL %s_result: got data=%h perr=%b ferr=%b, expected data=%h perr=%b ferr=%b",
                 name, out_data, parity_err, frame_err, exp_data, exp_perr, exp_ferr);
      end
      drive(1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_pulse: got out_valid=%b busy=%b, expected 0 0", name, out_valid, busy);
      end
    end
    $display("frame %s: data=%h perr=%b ferr=%b lat=%0d", name, out_data, parity_err,
             frame_err, cyc - start_cyc);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b1;
    #3;
    checks++;
    if ({busy, out_valid, out_data, parity_err, frame_err} !== '0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b ov=%b data=%h perr=%b ferr=%b, expected all 0",
               busy, out_valid, out_data, parity_err, frame_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_clean;
    send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clean_busy: got busy=%b ov=%b at stop, expected 1 0", busy, out_valid);
    end
    check_result("clean", 8'hA5, ODD, 1'b0, DATA_W + 3);
  endtask

  task automatic test_parity_err;
    send_frame(8'hA5, 1'b1, 1'b1, 0, 0);
    check_result("parity_p1", 8'hA5, ~ODD, 1'b0, DATA_W + 3);
    send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
    check_result("parity_p0", 8'hA5, ODD, 1'b0, DATA_W + 3);
  endtask

  task automatic test_frame_err;
    send_frame(8'h3C, 1'b0, 1'b0, 0, 0);
    check_result("frame_err", 8'h3C, ODD, 1'b1, DATA_W + 3);
    send_frame(8'h01, 1'b1, 1'b1, 0, 0);
    check_result("after_ferr", 8'h01, ODD, 1'b0, DATA_W + 3);
  endtask

  task automatic test_gaps;
    send_frame(8'hF0, 1'b0, 1'b1, 3, 2);
    check_result("gaps", 8'hF0, ODD, 1'b0, DATA_W + 3 + 5);
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, i[0]);
    @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy: got busy=%b, expected 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, out_valid, out_data, parity_err, frame_err} !== '0) begin
      failures++;
      $display("FAIL mid_reset: got busy=%b ov=%b data=%h perr=%b ferr=%b, expected all 0",
               busy, out_valid, out_data, parity_err, frame_err);
    end
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL mid_idle: got ov=%b busy=%b, expected 0 0", out_valid, busy);
      end
    end
    $display("mid-frame reset done");
    send_frame(8'h81, 1'b0, 1'b1, 0, 0);
    check_result("after_reset", 8'h81, ODD, 1'b0, DATA_W + 3);
  endtask

  task automatic test_back_to_back;
    send_frame(8'h3C, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0);  // next start bit immediately after stop
    start_cyc = cyc;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || frame_err !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: got ov=%b data=%h ferr=%b, expected 1 3c 1",
               out_valid, out_data, frame_err);
    end
    $display("frame b2b_first: data=%h ferr=%b", out_data, frame_err);
    send_body(8'h01, 1'b1, 1'b1, 0, 0);
    check_result("b2b_second", 8'h01, ODD, 1'b0, DATA_W + 3);
  endtask

  task automatic test_hold;
    repeat (5) drive(1'b1, 1'b1);
    checks++;
    if (out_data !== 8'h01 || parity_err !== ODD || frame_err !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold: got data=%h perr=%b ferr=%b ov=%b, expected 01 %b 0 0",
               out_data, parity_err, frame_err, out_valid, ODD);
    end
    $display("hold: data=%h perr=%b ferr=%b", out_data, parity_err, frame_err);
  endtask

  initial begin
    test_reset;
    test_clean;
    test_parity_err;
    test_frame_err;
    test_gaps;
    test_reset_mid;
    test_back_to_back;
    test_hold;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
